core_if_ifu: RTL and testbench
==============================

CORE_IF_IFU -- requirements
Module: core_if_ifu

Interface
REQ-001 Parameter RESET_PC, default `CORE_PC_WIDTH'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  core clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  `CORE_PC_WIDTH  fetch address, word aligned.
REQ-007 imem_rsp_valid  input  1  in-order response valid; always accepted.
REQ-008 imem_rsp_data  input  `CORE_INST_WIDTH  fetched instruction.
REQ-009 redirect_valid  input  1  backend flush and redirect, e.g. branch mispredict.
REQ-010 redirect_pc  input  `CORE_PC_WIDTH  new fetch PC.
REQ-011 valid_out  output  1  instruction available to decode.
REQ-012 ready_out  input  1  decode stage ready.
REQ-013 o_pc  output  `CORE_PC_WIDTH  PC of presented instruction.
REQ-014 o_inst  output  `CORE_INST_WIDTH  presented instruction.
REQ-015 o_branch_predict  output  1  instruction was predicted taken.

Function
REQ-016 Fetch PC register; request issued with imem_req_addr = fetch PC when credit exists; on handshake, fetch PC advances by 4 or to the predicted target.
REQ-017 Two-entry in-order instruction queue holding {pc, inst, predict}; head drives o_pc/o_inst/o_branch_predict; valid_out = queue not empty.
REQ-018 Credit rule: imem_req_valid = (outstanding + queue_count < 2) & ~redirect_valid, so every response always has a queue slot.
REQ-019 Outstanding counter 0..2: +1 on request handshake, -1 on response, both in same cycle leaves it unchanged.
REQ-020 Dequeue on valid_out & ready_out; enqueue and dequeue in same cycle allowed, count unchanged.
REQ-021 Minimum latency: request handshake cycle N, response cycle N+1, valid_out cycle N+2 with that instruction.
REQ-022 Queue PC tags come from a PC FIFO written at request handshake, read at response.
REQ-023 Redirect: in its cycle, queue cleared, valid_out held low next cycle, fetch PC <= redirect_pc, drop counter <= outstanding minus any response arriving that cycle; no request issued that cycle.
REQ-024 Responses while drop counter > 0 are discarded and decrement it; never enqueued.
REQ-025 Redirect outranks queue dequeue, response enqueue and internal prediction in the same cycle.
REQ-026 A redirect during a pending drop replaces the drop counter per REQ-023.
REQ-027 imem_req_valid may deassert without handshake; memory side shall tolerate this.
REQ-028 Fetch PC wraps modulo 2^`CORE_PC_WIDTH.

Reset
REQ-029 On rst_n low: fetch PC = RESET_PC, queue empty, outstanding = 0, drop = 0, valid_out = 0, imem_req_valid = 0, o_pc = 0, o_inst = 0, o_branch_predict = 0.
REQ-030 Reset mid-operation discards all in-flight requests; the first request after release is to RESET_PC, one cycle after rst_n deasserts.

Configuration
REQ-031 Macro CORE_IF_BPU_EN: when defined, an enqueued JAL, or a B-type with negative offset, gets predict = 1, fetch PC <= pc + imm, and drop counter <= remaining outstanding; that is a static BTFN prediction.
REQ-032 Without CORE_IF_BPU_EN: o_branch_predict is constant 0 and fetch is strictly sequential.

Verification
REQ-033 Reset release, memory 1-cycle, ready_out=1 -> requests 0x8000_0000, _0004, _0008; valid_out first high cycle 3 with o_pc 0x8000_0000.
REQ-034 ready_out=0 for 10 cycles -> queue holds 2, imem_req_valid low, no response lost, order preserved on release.
REQ-035 redirect_pc 0x8000_0100 with 2 outstanding -> both responses dropped, next o_pc 0x8000_0100.
REQ-036 Redirect in same cycle as response and dequeue -> response dropped, queue empty, fetch resumes at redirect_pc.
REQ-037 CORE_IF_BPU_EN, beq offset -8 at 0x8000_0010 -> o_branch_predict=1, next o_pc 0x8000_0008; undefined -> predict 0, next 0x8000_0014.
REQ-038 rst_n pulsed with 2 outstanding -> all outputs at reset values, late responses ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_if_ifu.sv
// -----------------------------------------------------------------------------
// core_if_ifu - instruction fetch unit
//
// Issues word-aligned fetch requests to instruction memory, tags the in-order
// responses with their PC and presents them to decode through a two-entry
// queue. Fetch is credit based: the number of outstanding requests plus the
// number of queued instructions never exceeds two. As a result, every response
// always has a free queue slot and the response channel needs no back-pressure.
//
// A backend redirect flushes the queue, moves the fetch PC and arms a drop
// counter. The drop counter discards the responses that are still in flight
// for the old path.
//
// Optional feature (macro CORE_IF_BPU_EN): static backward-taken /
// forward-not-taken prediction on enqueue. The feature applies to JAL and to
// B-type instructions with a negative offset. Without the macro,
// o_branch_predict is always 0 and fetch is strictly sequential.
//
// Ports:
//   clk, rst_n        core clock; asynchronous active-low reset
//   imem_req_*        fetch request channel (valid/ready, addr)
//   imem_rsp_*        in-order response channel (valid, data); always accepted
//   redirect_*        backend flush and new fetch PC
//   valid_out/ready_out/o_pc/o_inst/o_branch_predict
//                     instruction presented to decode (head of queue)
// -----------------------------------------------------------------------------

`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_if_ifu #(
   parameter logic [`CORE_PC_WIDTH-1:0] RESET_PC = `CORE_PC_WIDTH'h8000_0000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        imem_req_valid,
   input  logic                        imem_req_ready,
   output logic [`CORE_PC_WIDTH-1:0]   imem_req_addr,
   input  logic                        imem_rsp_valid,
   input  logic [`CORE_INST_WIDTH-1:0] imem_rsp_data,
   input  logic                        redirect_valid,
   input  logic [`CORE_PC_WIDTH-1:0]   redirect_pc,
   output logic                        valid_out,
   input  logic                        ready_out,
   output logic [`CORE_PC_WIDTH-1:0]   o_pc,
   output logic [`CORE_INST_WIDTH-1:0] o_inst,
   output logic                        o_branch_predict
);

   localparam int PCW = `CORE_PC_WIDTH;
   localparam int IW  = `CORE_INST_WIDTH;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PCW-1:0] r_fetch_pc;
   logic           r_started;     // holds off requests for the first cycle after reset
   logic [1:0]     r_out;         // outstanding requests, 0..2
   logic [1:0]     r_drop;        // responses still to be discarded

   // PC tag FIFO: written on request handshake, read on accepted response
   logic [PCW-1:0] r_pf_pc [2];
   logic           r_pf_rd;
   logic           r_pf_wr;

   // Instruction queue
   logic [PCW-1:0] r_q_pc   [2];
   logic [IW-1:0]  r_q_inst [2];
   logic           r_q_pred [2];
   logic           r_q_rd;
   logic           r_q_wr;
   logic [1:0]     r_q_cnt;

   // ---------------------------------------------------------------------------
   // Handshakes and next-state helpers
   // ---------------------------------------------------------------------------
   logic           w_req_valid;
   logic           w_req_hs;
   logic           w_rsp;
   logic           w_enq;
   logic           w_drop_rsp;
   logic           w_deq;
   logic [PCW-1:0] w_enq_pc;
   logic [1:0]     w_out_nxt;
   logic [1:0]     w_q_cnt_nxt;
   logic           w_pred;
   logic [PCW-1:0] w_target;

   assign w_req_valid = r_started & (({1'b0, r_out} + {1'b0, r_q_cnt}) < 3'd2) & ~redirect_valid;
   assign w_req_hs    = w_req_valid & imem_req_ready;

   // With nothing outstanding, a response can only be a leftover from before a
   // reset. Such a response is ignored.
   assign w_rsp       = imem_rsp_valid & (r_out != 2'd0);
   assign w_drop_rsp  = w_rsp & (r_drop != 2'd0);
   assign w_enq       = w_rsp & (r_drop == 2'd0);
   assign w_deq       = (r_q_cnt != 2'd0) & ready_out;
   assign w_enq_pc    = r_pf_pc[r_pf_rd];

   always_comb begin
      w_out_nxt = r_out;
      if (w_req_hs) w_out_nxt = w_out_nxt + 2'd1;
      if (w_rsp)    w_out_nxt = w_out_nxt - 2'd1;
   end

   always_comb begin
      w_q_cnt_nxt = r_q_cnt;
      if (w_enq) w_q_cnt_nxt = w_q_cnt_nxt + 2'd1;
      if (w_deq) w_q_cnt_nxt = w_q_cnt_nxt - 2'd1;
   end

   // ---------------------------------------------------------------------------
   // Static branch prediction on the instruction being enqueued
   // ---------------------------------------------------------------------------
`ifdef CORE_IF_BPU_EN
   logic        w_is_jal;
   logic        w_is_bneg;
   logic [20:0] w_jal_imm;
   logic [12:0] w_br_imm;

   assign w_is_jal  = (imem_rsp_data[6:0] == 7'b1101111);
   assign w_is_bneg = (imem_rsp_data[6:0] == 7'b1100011) & imem_rsp_data[31];
   assign w_jal_imm = {imem_rsp_data[31], imem_rsp_data[19:12], imem_rsp_data[20],
                       imem_rsp_data[30:21], 1'b0};
   assign w_br_imm  = {imem_rsp_data[31], imem_rsp_data[7], imem_rsp_data[30:25],
                       imem_rsp_data[11:8], 1'b0};
   assign w_pred    = w_enq & (w_is_jal | w_is_bneg);
   assign w_target  = w_enq_pc + (w_is_jal ? {{(PCW-21){w_jal_imm[20]}}, w_jal_imm}
                                            : {{(PCW-13){w_br_imm[12]}}, w_br_imm});
`else
   assign w_pred    = 1'b0;
   assign w_target  = '0;
`endif

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_started  <= 1'b0;
         r_out      <= 2'd0;
         r_drop     <= 2'd0;
         r_pf_rd    <= 1'b0;
         r_pf_wr    <= 1'b0;
         r_q_rd     <= 1'b0;
         r_q_wr     <= 1'b0;
         r_q_cnt    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_pf_pc[i]  <= '0;
            r_q_pc[i]   <= '0;
            r_q_inst[i] <= '0;
            r_q_pred[i] <= 1'b0;
         end
      end else begin
         r_started <= 1'b1;
         r_out     <= w_out_nxt;

         if (redirect_valid) begin
            // Everything still in flight belongs to the old path. Each of those
            // responses is dropped, so the tag FIFO restarts empty.
            r_fetch_pc <= redirect_pc;
            r_drop     <= r_out - {1'b0, w_rsp};
            r_pf_rd    <= 1'b0;
            r_pf_wr    <= 1'b0;
            r_q_rd     <= 1'b0;
            r_q_wr     <= 1'b0;
            r_q_cnt    <= 2'd0;
         end else begin
            // Tag FIFO
            if (w_pred) begin
               r_pf_rd <= 1'b0;
               r_pf_wr <= 1'b0;
            end else begin
               if (w_enq) r_pf_rd <= ~r_pf_rd;
               if (w_req_hs) begin
                  r_pf_pc[r_pf_wr] <= r_fetch_pc;
                  r_pf_wr          <= ~r_pf_wr;
               end
            end

            // Drop counter: a prediction discards everything fetched after it,
            // including a request accepted in this same cycle.
            if (w_pred)          r_drop <= w_out_nxt;
            else if (w_drop_rsp) r_drop <= r_drop - 2'd1;

            // Fetch PC (wraps naturally at the PC width)
            if (w_pred)        r_fetch_pc <= w_target;
            else if (w_req_hs) r_fetch_pc <= r_fetch_pc + PCW'(4);

            // Instruction queue
            if (w_enq) begin
               r_q_pc[r_q_wr]   <= w_enq_pc;
               r_q_inst[r_q_wr] <= imem_rsp_data;
               r_q_pred[r_q_wr] <= w_pred;
               r_q_wr           <= ~r_q_wr;
            end
            if (w_deq) r_q_rd <= ~r_q_rd;
            r_q_cnt <= w_q_cnt_nxt;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign imem_req_valid   = w_req_valid;
   assign imem_req_addr    = r_fetch_pc;
   assign valid_out        = (r_q_cnt != 2'd0);
   assign o_pc             = r_q_pc[r_q_rd];
   assign o_inst           = r_q_inst[r_q_rd];
   assign o_branch_predict = r_q_pred[r_q_rd];

endmodule

// File: tb/tb_core_if_ifu.sv
// -----------------------------------------------------------------------------
// tb_core_if_ifu - self-checking bench for core_if_ifu
//
// A transaction-level reference model (queues and integer counters) predicts
// the outputs for every cycle. A small in-order memory model serves the fetch
// requests. The bench runs a directed table for the start-up sequence, short
// hand-written sequences for stall, redirect, prediction and reset, and then
// randomized traffic.
// -----------------------------------------------------------------------------

module tb_core_if_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

`ifdef CORE_IF_BPU_EN
   localparam bit          EXP_BEQ_PRED = 1'b1;
   localparam logic [31:0] EXP_BEQ_NEXT = 32'h8000_0008;
`else
   localparam bit          EXP_BEQ_PRED = 1'b0;
   localparam logic [31:0] EXP_BEQ_NEXT = 32'h8000_0014;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_branch_predict;

   always #5 clk = ~clk;

   core_if_ifu #(.RESET_PC(RESET_PC)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .valid_out        (valid_out),
      .ready_out        (ready_out),
      .o_pc             (o_pc),
      .o_inst           (o_inst),
      .o_branch_predict (o_branch_predict)
   );

   typedef struct { logic [31:0] pc; logic [31:0] inst; bit pred; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct {
      bit          req_ready;
      bit          rdy_out;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_vld;
      logic [31:0] exp_pc;
   } vec_t;

   // Reference model state
   ent_t        m_q[$];
   logic [31:0] m_tags[$];
   int          m_out;
   int          m_drop;
   bit          m_started;
   logic [31:0] m_fetch;

   // Memory model: in-order pending requests
   mreq_t       mem_q[$];
   int          cyc = 0;

   int          n_cmp = 0;
   int          n_fail = 0;

   // Outputs sampled during the last step
   bit          s_req;
   bit          s_vld;
   bit          s_pred;
   logic [31:0] s_addr;
   logic [31:0] s_pc;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      if (a == 32'h8000_0010) return 32'hFE00_0CE3;  // beq x0, x0, -8
      return {a[26:2], 7'h13};
   endfunction

   // Static BTFN rule, as stated for the predictor
   function automatic bit bpu(input logic [31:0] pc, input logic [31:0] i,
                              output logic [31:0] tgt);
      logic signed [31:0] imm;
      bit hit;
      hit = 1'b0;
      tgt = pc;
      if (i[6:0] == 7'h6F) begin
         imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
         tgt = pc + imm;
         hit = 1'b1;
      end else if (i[6:0] == 7'h63 && i[31]) begin
         imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
         tgt = pc + imm;
         hit = 1'b1;
      end
`ifndef CORE_IF_BPU_EN
      hit = 1'b0;
`endif
      return hit;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit mem_due();
      return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
   endfunction

   // One clock cycle. Starts and ends just after a falling edge.
   task automatic step(input bit rq_rdy, input bit rsp_en, input bit redir,
                       input logic [31:0] rpc, input bit rdy_out);
      bit          exp_req;
      bit          hs;
      bit          rsp;
      bit          rsp_pop;
      bit          pr;
      logic [31:0] f0;
      logic [31:0] tgt;
      ent_t        e;

      imem_req_ready = rq_rdy;
      ready_out      = rdy_out;
      redirect_valid = redir;
      redirect_pc    = rpc;
      rsp_pop        = rsp_en && mem_due();
      imem_rsp_valid = rsp_pop;
      imem_rsp_data  = rsp_pop ? inst_of(mem_q[0].addr) : $urandom;
      #1;

      exp_req = m_started && (m_out + m_q.size() < 2) && !redir;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, m_fetch);
      chk("valid_out", 32'(valid_out), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("o_pc", o_pc, m_q[0].pc);
         chk("o_inst", o_inst, m_q[0].inst);
         chk("o_pred", 32'(o_branch_predict), 32'(m_q[0].pred));
      end
      s_req  = imem_req_valid;
      s_addr = imem_req_addr;
      s_vld  = valid_out;
      s_pc   = o_pc;
      s_pred = o_branch_predict;

      @(posedge clk);
      f0  = m_fetch;
      hs  = exp_req && rq_rdy;
      rsp = imem_rsp_valid && (m_out > 0);
      pr  = 1'b0;
      if (redir) begin
         m_q.delete();
         m_tags.delete();
         m_out   = m_out - (rsp ? 1 : 0);
         m_drop  = m_out;
         m_fetch = rpc;
      end else begin
         if (rdy_out && m_q.size() > 0) void'(m_q.pop_front());
         if (rsp) begin
            if (m_drop > 0) m_drop--;
            else begin
               e.pc   = m_tags.pop_front();
               e.inst = imem_rsp_data;
               e.pred = bpu(e.pc, e.inst, tgt);
               pr     = e.pred;
               m_q.push_back(e);
            end
         end
         if (hs) begin
            m_tags.push_back(m_fetch);
            m_fetch = m_fetch + 32'd4;
         end
         m_out = m_out + (hs ? 1 : 0) - (rsp ? 1 : 0);
         if (pr) begin
            m_fetch = tgt;
            m_tags.delete();
            m_drop = m_out;
         end
      end
      m_started = 1'b1;
      if (rsp_pop) void'(mem_q.pop_front());
      if (hs) mem_q.push_back('{addr: f0, due: cyc + 1});
      cyc++;
      @(negedge clk);
   endtask

   // Hold reset for two cycles and check the reset values. When late is set,
   // the memory keeps its pending requests and drives a response during reset.
   task automatic do_reset(input bit late);
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ready_out      = 1'b1;
      imem_rsp_valid = late;
      imem_rsp_data  = $urandom;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_o_pc", o_pc, 32'd0);
      chk("rst_o_inst", o_inst, 32'd0);
      chk("rst_o_pred", 32'(o_branch_predict), 32'd0);
      m_q.delete();
      m_tags.delete();
      m_out     = 0;
      m_drop    = 0;
      m_started = 1'b0;
      m_fetch   = RESET_PC;
      if (!late) mem_q.delete();
      repeat (2) @(negedge clk);
      chk("rst_hold_req", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b0;
      rst_n          = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[8];
      bit          found;
      logic [31:0] h;

      tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,           1'b0, 32'h0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,           1'b1, 32'h8000_0000};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b0, 32'h0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,           1'b1, 32'h8000_0008};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C};

      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ready_out      = 1'b0;
      @(negedge clk);
      do_reset(1'b0);

      // Start-up sequence, 1-cycle memory, decode always ready
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].req_ready, 1'b1, 1'b0, 32'h0, tbl[i].rdy_out);
         chk("tbl_req", 32'(s_req), 32'(tbl[i].exp_req));
         if (tbl[i].exp_req) chk("tbl_addr", s_addr, tbl[i].exp_addr);
         chk("tbl_vld", 32'(s_vld), 32'(tbl[i].exp_vld));
         if (tbl[i].exp_vld) chk("tbl_pc", s_pc, tbl[i].exp_pc);
      end

      // Backward beq at 0x8000_0010
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         if (s_vld && s_pc == 32'h8000_0010) found = 1'b1;
      end
      chk("beq_seen", 32'(found), 32'd1);
      chk("beq_pred", 32'(s_pred), 32'(EXP_BEQ_PRED));
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         if (s_vld) found = 1'b1;
      end
      chk("beq_next_seen", 32'(found), 32'd1);
      chk("beq_next_pc", s_pc, EXP_BEQ_NEXT);

      // Redirect with two requests outstanding
      for (int i = 0; i < 20 && m_out < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rd_two_out", 32'(m_out), 32'd2);
      step(1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b1);
      chk("rd_no_req", 32'(s_req), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         if (s_vld) found = 1'b1;
      end
      chk("rd_seen", 32'(found), 32'd1);
      chk("rd_first_pc", s_pc, 32'h8000_0100);

      // Decode stalled for 10 cycles
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_vld", 32'(s_vld), 32'd1);
      chk("stall_req", 32'(s_req), 32'd0);
      h = s_pc;
      for (int k = 0; k < 3; k++) begin
         found = 1'b0;
         for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            if (s_vld) found = 1'b1;
         end
         chk("stall_order", s_pc, h + 32'(4 * k));
      end

      // Redirect in the same cycle as a response and a dequeue
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_q.size() > 0 && mem_due()) begin
            step(1'b1, 1'b1, 1'b1, 32'h8000_0200, 1'b1);
            found = 1'b1;
         end else begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         end
      end
      chk("r3_hit", 32'(found), 32'd1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("r3_vld_low", 32'(s_vld), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (s_vld) found = 1'b1;
         else step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      end
      chk("r3_pc", s_pc, 32'h8000_0200);

      // Reset pulse with two requests outstanding; late responses follow
      for (int i = 0; i < 20 && m_out < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rs_two_out", 32'(m_out), 32'd2);
      do_reset(1'b1);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         if (s_req) found = 1'b1;
      end
      chk("rs_req_seen", 32'(found), 32'd1);
      chk("rs_req_addr", s_addr, RESET_PC);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         if (s_vld) found = 1'b1;
      end
      chk("rs_vld_seen", 32'(found), 32'd1);
      chk("rs_first_pc", s_pc, RESET_PC);

      // Randomized traffic, including redirects close to the top of the PC space
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3))
                                           : 32'h8000_0100 + 32'(4 * $urandom_range(0, 63));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 29) == 0, rpc, $urandom_range(0, 9) < 7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
